// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit placed after the ALU. It accepts a LOAD or
// STORE instruction, performs one handshaked word-wide data-memory access
// and returns lane-extracted, sign/zero-extended load data with a one-cycle
// done pulse.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses skip memory and finish
//               with misaligned=1.
//   undefined : misaligned is tied low and the byte offset is forced to
//               natural alignment.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               accept an operation (honoured in IDLE only)
//   op_code, funct3     instruction opcode and size/signedness
//   alu_result          effective byte address
//   store_data          rs2 value
//   busy, done          status / one-cycle completion pulse
//   load_data           extended load result, held until the next load
//   misaligned          valid with done
//   mem_req/we/addr/wdata/wmask   memory request channel
//   mem_ready           request accepted
//   mem_rvalid/rdata    read response
// ---------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  op_code,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic [31:0] load_data_q;

  logic        is_load_s;
  logic        is_store_s;
  logic        legal_s;
  logic        mis_s;
  logic [1:0]  off_s;
  logic [3:0]  wmask_s;
  logic [31:0] wdata_s;
  logic        accept_s;
  logic        rdata_cap_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ext_s;

  // Decode the incoming instruction into load/store legality.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    if (op_code == OP_LOAD) begin
      case (funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: is_load_s = 1'b1;
        default:                      is_load_s = 1'b0;
      endcase
    end else if (op_code == OP_STORE) begin
      case (funct3)
        3'd0, 3'd1, 3'd2: is_store_s = 1'b1;
        default:          is_store_s = 1'b0;
      endcase
    end else begin
      is_load_s  = 1'b0;
      is_store_s = 1'b0;
    end
  end

  assign legal_s = is_load_s | is_store_s;

  // Byte offset forced to natural alignment for the access size; with the
  // check enabled, misaligned accesses never reach memory, so forcing is
  // harmless there too.
  always_comb begin
    off_s = 2'b00;
    case (funct3[1:0])
      2'd0:    off_s = alu_result[1:0];
      2'd1:    off_s = {alu_result[1], 1'b0};
      default: off_s = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis_s = legal_s &
                 (((funct3[1:0] == 2'd1) & alu_result[0]) |
                  ((funct3[1:0] == 2'd2) & (alu_result[1:0] != 2'b00)));
`else
  assign mis_s = 1'b0;
`endif

  // Store byte enables and lane-replicated write data.
  always_comb begin
    wmask_s = 4'b0000;
    wdata_s = 32'h0000_0000;
    if (is_store_s) begin
      case (funct3)
        3'd0: begin
          wmask_s = 4'b0001 << off_s;
          wdata_s = {4{store_data[7:0]}};
        end
        3'd1: begin
          wmask_s = 4'b0011 << off_s;
          wdata_s = {2{store_data[15:0]}};
        end
        3'd2: begin
          wmask_s = 4'b1111;
          wdata_s = store_data;
        end
        default: begin
          wmask_s = 4'b0000;
          wdata_s = 32'h0000_0000;
        end
      endcase
    end else begin
      wmask_s = 4'b0000;
      wdata_s = 32'h0000_0000;
    end
  end

  assign accept_s    = (state_q == IDLE) & start;
  assign rdata_cap_s = (state_q == RDATA) & mem_rvalid;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal_s && !mis_s) begin
            state_d = REQ;
          end else begin
            state_d = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = mem_we_q ? FIN : RDATA;
        end else begin
          state_d = REQ;
        end
      end
      RDATA: begin
        if (mem_rvalid) begin
          state_d = FIN;
        end else begin
          state_d = RDATA;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    byte_s = 8'h00;
    case (off_q)
      2'd0:    byte_s = mem_rdata[7:0];
      2'd1:    byte_s = mem_rdata[15:8];
      2'd2:    byte_s = mem_rdata[23:16];
      2'd3:    byte_s = mem_rdata[31:24];
      default: byte_s = mem_rdata[7:0];
    endcase
    half_s = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext_s  = mem_rdata;
    case (funct3_q)
      3'd0:    ext_s = {{24{byte_s[7]}}, byte_s};
      3'd1:    ext_s = {{16{half_s[15]}}, half_s};
      3'd2:    ext_s = mem_rdata;
      3'd4:    ext_s = {24'h00_0000, byte_s};
      3'd5:    ext_s = {16'h0000, half_s};
      default: ext_s = mem_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misal_q;

  // Misalignment flag captured on acceptance, shown only during FIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      misal_q <= 1'b0;
    end else if (accept_s) begin
      misal_q <= mis_s;
    end
  end

  assign misaligned = misal_q & (state_q == FIN);
`else
  assign misaligned = 1'b0;
`endif

  // State, captured operands, memory request and load result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_wmask_q <= 4'b0000;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        funct3_q    <= funct3;
        off_q       <= off_s;
        mem_we_q    <= is_store_s;
        mem_addr_q  <= {alu_result[31:2], 2'b00};
        mem_wdata_q <= wdata_s;
        mem_wmask_q <= wmask_s;
      end
      if (rdata_cap_s) begin
        load_data_q <= ext_s;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a small reference model pushes
// expected results into a scoreboard queue when each operation is driven;
// they are popped and compared when the unit signals done.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  op_code = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy, done, misaligned, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] ld_model = 32'd0;

  typedef struct {
    logic        exp_req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] ld;
    logic        mis;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .op_code(op_code),
    .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data), .misaligned(misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model; updates the running load_data expectation.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int rdly, input int vdly);
    exp_t e;
    logic ld, st, mis;
    logic [1:0] ob;
    logic [31:0] sh;
    ld  = (op == LD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st  = (op == ST) && (f3 inside {3'd0, 3'd1, 3'd2});
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (ld || st)
      mis = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a[1:0] != 2'd0));
`endif
    e.exp_req = 1'b0; e.we = 1'b0; e.addr = 32'd0; e.wdata = 32'd0;
    e.wmask = 4'd0; e.mis = mis; e.lat = 1;
    if ((ld || st) && !mis) begin
      e.exp_req = 1'b1;
      e.we   = st;
      e.addr = {a[31:2], 2'b00};
      ob = (f3[1:0] == 2'd0) ? a[1:0] : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : 2'd0;
      if (st) begin
        e.wmask = (f3 == 3'd0) ? (4'b0001 << ob) : (f3 == 3'd1) ? (4'b0011 << ob) : 4'b1111;
        e.wdata = (f3 == 3'd0) ? {4{sd[7:0]}} : (f3 == 3'd1) ? {2{sd[15:0]}} : sd;
        e.lat   = 2 + rdly;
      end else begin
        sh = rd >> (8 * ob);
        case (f3)
          3'd0:    ld_model = {{24{sh[7]}}, sh[7:0]};
          3'd1:    ld_model = {{16{sh[15]}}, sh[15:0]};
          3'd4:    ld_model = {24'd0, sh[7:0]};
          3'd5:    ld_model = {16'd0, sh[15:0]};
          default: ld_model = rd;
        endcase
        e.lat = 3 + rdly + vdly;
      end
    end
    e.ld = ld_model;
    return e;
  endfunction

  // Drive one operation and act as the memory; spam=1 holds start high with
  // a different instruction for the whole operation, including FIN.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int rdly, input int vdly, input bit spam);
    exp_t e, p;
    int cyc = 0, cnt = 0, phase = 0;
    bit got = 0, req_seen = 0;
    e = model(op, f3, a, sd, rd, rdly, vdly);
    sb_q.push_back(e);
    op_code = op; funct3 = f3; alu_result = a; store_data = sd; start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      if (spam) begin
        start = 1'b1; op_code = ST; funct3 = 3'd2; alu_result = 32'h0000_0F00;
      end else begin
        start = 1'b0; op_code = 7'($urandom); funct3 = 3'($urandom);
        alu_result = $urandom; store_data = $urandom;
      end
      if (done) begin
        got = 1;
        break;
      end
      check_eq("busy_during_op", {31'd0, busy}, 32'd1);
      if (phase == 0) begin
        if (mem_req) begin
          req_seen = 1;
          check_eq("mem_addr", mem_addr, e.addr);
          check_eq("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          check_eq("mem_wmask", {28'd0, mem_wmask}, {28'd0, e.wmask});
          if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
          if (cnt == rdly) begin
            mem_ready = 1'b1;
            phase = e.we ? 2 : 1;
            cnt = 0;
          end else begin
            cnt++;
            mem_rvalid = 1'b1;
            mem_rdata = ~rd;
          end
        end
      end else if (phase == 1) begin
        if (cnt == vdly) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd;
          phase = 2;
        end else begin
          cnt++;
        end
      end
    end
    if (!got) check_eq("done_timeout", 32'd0, 32'd1);
    p = sb_q.pop_front();
    check_eq("latency", cyc, p.lat);
    check_eq("mem_req_seen", {31'd0, req_seen}, {31'd0, p.exp_req});
    check_eq("load_data", load_data, p.ld);
    check_eq("misaligned", {31'd0, misaligned}, {31'd0, p.mis});
    @(negedge clk);
    check_eq("done_after_fin", {31'd0, done}, 32'd0);
    check_eq("busy_after_fin", {31'd0, busy}, 32'd0);
    start = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    check_eq("rst_load_data", load_data, 32'd0);
    reset = 1'b0;

    // Reset in RDATA, then a stray rvalid.
    @(negedge clk);
    op_code = LD; funct3 = 3'd2; alu_result = 32'h0000_0040; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("rstmid_req", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq("rstmid_in_rdata", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rstmid_busy", {31'd0, busy}, 32'd0);
    check_eq("rstmid_req_drop", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      check_eq("rstmid_no_done", {31'd0, done}, 32'd0);
      check_eq("rstmid_ld_zero", load_data, 32'd0);
    end

    // Directed operations.
    run_op(ST, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'd0, 0, 0, 0);
    run_op(ST, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 0, 0);
    run_op(LD, 3'd0, 32'h0000_2002, 32'd0, 32'h0080_FF00, 0, 2, 0);
    run_op(LD, 3'd4, 32'h0000_2002, 32'd0, 32'h0080_FF00, 0, 2, 0);
    run_op(LD, 3'd1, 32'h0000_2001, 32'd0, 32'h1234_F00D, 0, 0, 0);
    run_op(LD, 3'd3, 32'h0000_2000, 32'd0, 32'h5555_5555, 0, 0, 0);
    run_op(ST, 3'd1, 32'h0000_1006, 32'h1234_ABCD, 32'd0, 2, 0, 1);
    run_op(LD, 3'd5, 32'h0000_3002, 32'd0, 32'h8001_1234, 1, 1, 1);
    run_op(LD, 3'd2, 32'h0000_3004, 32'd0, 32'hCAFE_F00D, 0, 0, 0);
    run_op(7'h33, 3'd0, 32'h0000_3000, 32'd0, 32'h0, 0, 0, 0);
    run_op(ST, 3'd4, 32'h0000_3000, 32'h1111_1111, 32'h0, 0, 0, 0);
    run_op(LD, 3'd1, 32'h0000_2006, 32'd0, 32'h8765_4321, 0, 0, 0);

    // Randomised mix, including illegal encodings.
    for (int k = 0; k < 24; k++) begin
      logic [6:0] op;
      case ($urandom_range(0, 4))
        0, 1:    op = LD;
        2, 3:    op = ST;
        default: op = 7'h13;
      endcase
      run_op(op, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the RISC-V datapath, sitting directly downstream of the ALU. For LOAD (op_code 7'b0000011) and STORE (7'b0100011) instructions it takes the ALU's effective address (rs1 + imm), performs a handshaked word-wide data-memory access, and applies byte lanes, write masks and sign/zero extension. It returns writeback data to the control unit with a one-cycle completion pulse.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  accept an operation this cycle; honoured only in IDLE.
- op_code  in  7  instruction opcode.
- funct3  in  3  access size/signedness.
- alu_result  in  32  effective byte address from the ALU.
- store_data  in  32  rs2 value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; holds until the next load completes.
- misaligned  out  1  valid with done; see Configuration.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, alu_result with [1:0] = 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_wmask  out  4  byte enables; 0 for reads.
- mem_ready  in  1  memory accepts the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

## Operation
- Legal operations:
  - Loads, by funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores, by funct3: 0 SB, 1 SH, 2 SW.
  - Any other op_code/funct3 is illegal: no memory access, done pulses, load_data unchanged.
- Operands (alu_result, funct3, op_code, store_data) are captured on the accepting edge. Later input changes have no effect.
- States:
  - IDLE: on start, legal → REQ; illegal → FIN.
  - REQ: mem_req=1 with mem_addr/mem_we/mem_wdata/mem_wmask stable. On mem_req&mem_ready: store → FIN, load → RDATA.
  - RDATA: on mem_rvalid, capture the extracted result into load_data → FIN.
  - FIN: done=1 → IDLE.
- Stores:
  - SB: mask = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: mask = 4'b0011 << (2*addr[1]), wdata = {2{rs2[15:0]}}.
  - SW: mask = 4'b1111, wdata = rs2.
- Loads:
  - Byte lane selected by addr[1:0]; halfword lane selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- mem_rvalid outside RDATA and mem_ready outside REQ are ignored.

## Timing
- Reset values: state IDLE; busy, done, misaligned, mem_req, mem_we = 0; mem_addr, mem_wdata, load_data = 0; mem_wmask = 0.
- Reset mid-operation: IDLE from the sampling edge. mem_req drops at that edge, no done is produced, and later mem_rvalid is ignored.
- Store with mem_ready high immediately: start at cycle 0, REQ at 1, FIN/done at 2.
- Load with ready at cycle 1 and rvalid at 2: FIN/done at 3; load_data valid from cycle 3.
- Each ready/rvalid stall cycle adds one cycle of latency.
- Read data must arrive at least one cycle after acceptance; rvalid coincident with acceptance is not used.
- start while busy (including FIN) is dropped; the control unit holds the instruction until done.
- done and busy are never high in IDLE. Back-to-back start is possible on the cycle after FIN.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned accesses skip REQ and go IDLE → FIN, with done and misaligned=1 and load_data unchanged.
  - A halfword with addr[0]=1 is misaligned.
  - A word with addr[1:0]≠0 is misaligned.
- Undefined: misaligned is tied 0. The offset is forced to natural alignment (addr[0] cleared for halfword, addr[1:0] cleared for word) and the access proceeds normally.

## Test plan
- SW addr 0x1000, rs2 0xDEADBEEF, ready at once → mem_addr 0x1000, wmask 4'b1111, wdata 0xDEADBEEF, done at cycle 2.
- SB addr 0x1003, rs2 0x000000A5 → wmask 4'b1000, wdata 0xA5A5A5A5.
- LB addr 0x2002, rdata 0x0080FF00, rvalid two cycles late → load_data 0xFFFFFF80, done at cycle 5. LBU at the same address → 0x00000080.
- LH addr 0x2001:
  - With LSU_MISALIGN_CHECK_EN: no mem_req, misaligned=1 with done at cycle 1.
  - Without: reads lane 0; rdata 0x1234F00D → 0xFFFFF00D.
- Reset asserted in RDATA, then rvalid=1 → no done, load_data stays 0. start during busy is ignored and the next start after FIN is accepted.
- funct3=3 load → no mem_req, done at cycle 1, load_data unchanged.
